// File: rtl/mode_select_pkg.sv
// Shared types and constants for the password-driven mode selector.
package mode_select_pkg;

  // Debounce / commit state machine.
  typedef enum logic [1:0] {
    STABLE   = 2'd0,
    SETTLING = 2'd1,
    PENDING  = 2'd2
  } state_e;

  // The "no password matched" channel index sits just past the real channels.
  function automatic int unsigned DEFAULT_CH(input int unsigned num_ch);
    return num_ch;
  endfunction

endpackage

// File: rtl/pw_decode.sv
// Priority match of the switch bank against the programmed passwords.
// Lowest-index enabled channel wins; no match yields the default channel.
module pw_decode
  import mode_select_pkg::*;
#(
  parameter int                       NUM_CH    = 4,
  parameter int                       SW_W      = 16,
  parameter int                       CH_W      = 3,
  parameter logic [NUM_CH*SW_W-1:0]   PASSWORDS = '0,
  parameter logic [NUM_CH-1:0]        CH_EN     = '1
) (
  input  logic [SW_W-1:0] sw_i,
  output logic [CH_W-1:0] match_ch_o
);

  logic [NUM_CH-1:0] hit;

  // A disabled channel is masked out so it can never be selected.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_hit
    assign hit[gi] = CH_EN[gi] && (sw_i == PASSWORDS[gi*SW_W +: SW_W]);
  end

  // Scan from the top down so the lowest matching index overrides the rest.
  always_comb begin
    match_ch_o = CH_W'(DEFAULT_CH(NUM_CH));
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (hit[i]) match_ch_o = CH_W'(i);
    end
  end

endmodule

// File: rtl/mode_select_mux.sv
// Debounced, frame-aligned feature selector. The switch bank is decoded to a
// candidate channel, which must hold steady before it is accepted; the switch
// itself is optionally deferred to an OLED frame boundary. LED and pixel
// outputs are registered from the committed channel.
module mode_select_mux
  import mode_select_pkg::*;
#(
  parameter int                       NUM_CH        = 4,
  parameter int                       SW_W          = 16,
  parameter int                       LED_W         = 16,
  parameter int                       PIX_W         = 16,
  parameter logic [NUM_CH*SW_W-1:0]   PASSWORDS     = {16'h8195, 16'h0000, 16'h2265, 16'h138D},
  parameter logic [NUM_CH-1:0]        CH_EN         = 4'b1011,
  parameter int                       STABLE_CYCLES = 1_000_000,
  parameter int                       FRAME_ALIGN   = 1
) (
  input  logic                          clock_100mhz,
  input  logic                          reset,
  input  logic [SW_W-1:0]               sw,
  input  logic                          frame_begin,
  input  logic [NUM_CH*LED_W-1:0]       led_in,
  input  logic [NUM_CH*PIX_W-1:0]       oled_in,
  input  logic [PIX_W-1:0]              oled_default,
  output logic [LED_W-1:0]              led,
  output logic [PIX_W-1:0]              oled_data,
  output logic [$clog2(NUM_CH+1)-1:0]   active_ch,
  output logic                          switch_pulse
);

  localparam int CH_W  = $clog2(NUM_CH + 1);
  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  // The cycle in which the candidate is first seen already counts as one
  // stable cycle, so SETTLING finishes one count early.
  localparam int LAST_CNT = (STABLE_CYCLES >= 2) ? STABLE_CYCLES - 2 : 0;
  localparam logic [CH_W-1:0]  DEF_CH  = CH_W'(DEFAULT_CH(NUM_CH));
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(LAST_CNT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  logic [CH_W-1:0]  dec_ch;
  logic [CH_W-1:0]  cand_q;
  logic [CH_W-1:0]  active_q, active_d;
  logic [CH_W-1:0]  tgt_q, tgt_d;
  logic [CH_W-1:0]  pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_e           state_q, state_d;
  logic             pulse_q, pulse_d;
  logic [LED_W-1:0] led_q, led_d;
  logic [PIX_W-1:0] oled_q, oled_d;
  logic             do_settle;
  logic [CH_W-1:0]  settle_ch;

  pw_decode #(
    .NUM_CH   (NUM_CH),
    .SW_W     (SW_W),
    .CH_W     (CH_W),
    .PASSWORDS(PASSWORDS),
    .CH_EN    (CH_EN)
  ) u_pw_decode (
    .sw_i      (sw),
    .match_ch_o(dec_ch)
  );

  // Next-state logic: track how long the candidate has held, then commit.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tgt_d     = tgt_q;
    pend_d    = pend_q;
    active_d  = active_q;
    pulse_d   = 1'b0;
    do_settle = 1'b0;
    settle_ch = tgt_q;

    case (state_q)
      STABLE: begin
        if (cand_q != active_q) begin
          tgt_d = cand_q;
          cnt_d = '0;
          if (STABLE_CYCLES == 1) begin
            do_settle = 1'b1;
            settle_ch = cand_q;
          end else begin
            state_d = SETTLING;
          end
        end
      end

      SETTLING: begin
        if (cand_q == active_q) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cand_q != tgt_q) begin
          // A different candidate restarts the debounce from scratch.
          tgt_d = cand_q;
          cnt_d = '0;
        end else if (cnt_q == CNT_END) begin
          do_settle = 1'b1;
          settle_ch = tgt_q;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      PENDING: begin
        // A candidate change outranks a frame boundary in the same cycle.
        if (cand_q != pend_q) begin
          cnt_d = '0;
          tgt_d = cand_q;
          if (cand_q == active_q) begin
            state_d = STABLE;
          end else if (STABLE_CYCLES == 1) begin
            do_settle = 1'b1;
            settle_ch = cand_q;
          end else begin
            state_d = SETTLING;
          end
        end else if (frame_begin) begin
          active_d = pend_q;
          pulse_d  = 1'b1;
          state_d  = STABLE;
        end
      end

      default: begin
        state_d = STABLE;
        cnt_d   = '0;
      end
    endcase

    // Debounce complete: either switch now or wait for the next frame.
    if (do_settle) begin
      cnt_d = '0;
      if (FRAME_ALIGN != 0) begin
        pend_d  = settle_ch;
        state_d = PENDING;
      end else begin
        active_d = settle_ch;
        pulse_d  = 1'b1;
        state_d  = STABLE;
      end
    end
  end

  // Output selection from the committed channel; default shows the switches.
  always_comb begin
    led_d  = LED_W'(sw);
    oled_d = oled_default;
    for (int i = 0; i < NUM_CH; i++) begin
      if (active_q == CH_W'(i)) begin
        led_d  = led_in[i*LED_W +: LED_W];
        oled_d = oled_in[i*PIX_W +: PIX_W];
      end
    end
  end

  // Candidate, FSM and output registers; reset drops all debounce progress.
  always_ff @(posedge clock_100mhz or posedge reset) begin
    if (reset) begin
      cand_q   <= DEF_CH;
      active_q <= DEF_CH;
      tgt_q    <= DEF_CH;
      pend_q   <= DEF_CH;
      cnt_q    <= '0;
      state_q  <= STABLE;
      pulse_q  <= 1'b0;
      led_q    <= '0;
      oled_q   <= '0;
    end else begin
      cand_q   <= dec_ch;
      active_q <= active_d;
      tgt_q    <= tgt_d;
      pend_q   <= pend_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      pulse_q  <= pulse_d;
      led_q    <= led_d;
      oled_q   <= oled_d;
    end
  end

  assign led          = led_q;
  assign oled_data    = oled_q;
  assign active_ch    = active_q;
  assign switch_pulse = pulse_q;

endmodule
